tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, idle cycles inserted after each Tx_Done_in (legal range 1..255).
REQ-002 SHALL have parameter HOLD_TIMEOUT, default 1000, cycles a locked packet may stall before forced release (legal range 1..65535).
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports Req0_Valid_in / Req1_Valid_in  input  1 each  requester byte valid.
REQ-006 SHALL have ports Req0_Byte_in / Req1_Byte_in  input  8 each  requester byte.
REQ-007 SHALL have ports Req0_Last_in / Req1_Last_in  input  1 each  byte is final byte of packet.
REQ-008 SHALL have ports Req0_Ready_out / Req1_Ready_out  output  1 each  byte accepted when Valid and Ready are high in the same cycle.
REQ-009 SHALL have port Tx_DV_out  output  1  one-cycle start strobe to UART transmitter.
REQ-010 SHALL have port Tx_Byte_out  output  8  byte to transmitter.
REQ-011 SHALL have port Tx_Done_in  input  1  one-cycle transmitter completion pulse.
REQ-012 SHALL have port Grant_out  output  2  one-hot owner of transmitter; 00 when none.
REQ-013 SHALL have port Busy_out  output  1  high in every state except IDLE.
REQ-014 SHALL have port Timeout_out  output  1  one-cycle pulse on forced lock release.

Function
REQ-015 SHALL implement states IDLE, SEND, WAIT, GAP, HOLD.
REQ-016 IDLE: winner = requester with Valid high; if both, winner = round-robin pointer (reset 0); only the winner's Ready_out SHALL be high, combinationally.
REQ-017 On accept in IDLE: latch byte and Last, set Grant_out to winner, go SEND.
REQ-018 SEND: Tx_DV_out SHALL be high exactly this one cycle; go WAIT.
REQ-019 Tx_Byte_out SHALL present the latched byte from SEND until the next accept, unchanged during WAIT and GAP.
REQ-020 WAIT: hold until Tx_Done_in; Tx_Done_in in any other state SHALL be ignored.
REQ-021 On Tx_Done_in with latched Last=1: pointer SHALL become the other requester, Grant_out SHALL clear, lock cleared; go GAP.
REQ-022 On Tx_Done_in with latched Last=0: lock held, Grant_out kept; go GAP.
REQ-023 GAP: stay exactly GAP_CYCLES cycles, Ready_out both low; then HOLD if locked, else IDLE.
REQ-024 HOLD: only granted requester's Ready_out high; accept latches byte/Last, goes SEND; other requester's Valid ignored.
REQ-025 HOLD: counter SHALL count cycles without accept; at HOLD_TIMEOUT, pulse Timeout_out, clear lock and Grant_out, pointer to other requester, go IDLE.
REQ-026 Latency: accept at cycle N -> Tx_DV_out at N+1; Tx_Done_in at M -> Ready_out earliest at M+GAP_CYCLES+1.
REQ-027 Requester with Valid low SHALL never be granted; single valid requester SHALL win regardless of pointer.
REQ-028 Accept and Timeout in the same HOLD cycle: accept SHALL take priority, no Timeout_out pulse.

Reset
REQ-029 While RST high: state IDLE, pointer 0, lock 0, GAP/HOLD counters 0, Tx_DV_out 0, Tx_Byte_out 0x00, Grant_out 00, Busy_out 0, Timeout_out 0, both Ready_out 0.
REQ-030 RST mid-operation SHALL abort the packet without another Tx_DV_out; a Tx_Done_in arriving after reset SHALL be ignored.

Verification
REQ-031 Single byte: Req0 Valid, Byte=0x41, Last=1 in IDLE -> Ready0 high, Tx_DV_out next cycle with 0x41; Done -> 2 GAP cycles -> IDLE, pointer=1.
REQ-032 Contention: both Valid after reset, Last=1 -> Req0 served first, then Req1; repeated contention alternates 0,1,0,1.
REQ-033 Packet lock: Req1 sends 0x10,0x11,0x12 (Last on 0x12) while Req0 Valid continuously -> three Req1 bytes sent back-to-back before any Req0 byte.
REQ-034 Timeout: HOLD_TIMEOUT=8, Req0 sends Last=0 then drops Valid -> Timeout_out pulse 8 cycles after HOLD entry, Grant_out 00, Req1 granted next.
REQ-035 Reset in WAIT: assert RST one cycle, then Tx_Done_in -> all outputs at reset values, no Tx_DV_out, state IDLE.
REQ-036 Spurious Tx_Done_in in IDLE/HOLD/GAP -> no state change, no extra Tx_DV_out.

Source files
------------

// File: rtl/tx_arbiter.sv
// tx_arbiter: two-requester round-robin arbiter feeding a UART transmitter with packet lock, inter-byte gap and hold timeout
module tx_arbiter #(
  parameter int GAP_CYCLES   = 2,
  parameter int HOLD_TIMEOUT = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Req0_Valid_in,
  input  logic       Req1_Valid_in,
  input  logic [7:0] Req0_Byte_in,
  input  logic [7:0] Req1_Byte_in,
  input  logic       Req0_Last_in,
  input  logic       Req1_Last_in,
  output logic       Req0_Ready_out,
  output logic       Req1_Ready_out,
  output logic       Tx_DV_out,
  output logic [7:0] Tx_Byte_out,
  input  logic       Tx_Done_in,
  output logic [1:0] Grant_out,
  output logic       Busy_out,
  output logic       Timeout_out
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, GAP, HOLD} state_t;
  state_t      state;
  logic        ptr;
  logic        lock;
  logic        last;
  logic [7:0]  gap_cnt;
  logic [15:0] hold_cnt;
  logic        win1;
  logic        acc0;
  logic        acc1;
  // Pick the IDLE winner and expose Ready only to the current owner
  always_comb begin
    win1 = (Req0_Valid_in & Req1_Valid_in) ? ptr : Req1_Valid_in;
    Req0_Ready_out = ~RST & ((state == IDLE) ? (Req0_Valid_in & ~win1) : (state == HOLD) & Grant_out[0]);
    Req1_Ready_out = ~RST & ((state == IDLE) ? (Req1_Valid_in & win1) : (state == HOLD) & Grant_out[1]);
    acc0 = Req0_Ready_out & Req0_Valid_in;
    acc1 = Req1_Ready_out & Req1_Valid_in;
  end
  assign Busy_out = (state != IDLE);
  // Arbitration FSM; a packet stays locked to its owner until Last completes or the hold times out
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      lock        <= 1'b0;
      last        <= 1'b0;
      gap_cnt     <= '0;
      hold_cnt    <= '0;
      Tx_DV_out   <= 1'b0;
      Tx_Byte_out <= 8'h00;
      Grant_out   <= 2'b00;
      Timeout_out <= 1'b0;
    end else begin
      Tx_DV_out   <= 1'b0;
      Timeout_out <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          if (acc0 | acc1) begin
            Tx_Byte_out <= acc1 ? Req1_Byte_in : Req0_Byte_in;
            last        <= acc1 ? Req1_Last_in : Req0_Last_in;
            Grant_out   <= acc1 ? 2'b10 : 2'b01;
            Tx_DV_out   <= 1'b1;
            hold_cnt    <= '0;
            state       <= SEND;
          end else if (state == HOLD) begin
            if (hold_cnt == 16'(HOLD_TIMEOUT - 1)) begin
              Timeout_out <= 1'b1;
              Grant_out   <= 2'b00;
              lock        <= 1'b0;
              ptr         <= ~Grant_out[1];
              hold_cnt    <= '0;
              state       <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (Tx_Done_in) begin
            gap_cnt <= '0;
            state   <= GAP;
            lock    <= ~last;
            if (last) begin
              ptr       <= ~Grant_out[1];
              Grant_out <= 2'b00;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
            gap_cnt  <= '0;
            hold_cnt <= '0;
            state    <= lock ? HOLD : IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed self-checking bench for tx_arbiter
module tb_tx_arbiter;
  logic       clk = 0;
  logic       rst = 0;
  logic       v0 = 0, v1 = 0, l0 = 0, l1 = 0, done = 0;
  logic [7:0] b0 = 0, b1 = 0;
  logic       r0, r1, dv, busy, tmo;
  logic [7:0] tx_byte;
  logic [1:0] grant;
  int         tests = 0;
  int         fails = 0;
  int         dv_cnt = 0;
  int         snap;

  tx_arbiter #(.GAP_CYCLES(2), .HOLD_TIMEOUT(8)) dut (
    .CLK(clk), .RST(rst),
    .Req0_Valid_in(v0), .Req1_Valid_in(v1),
    .Req0_Byte_in(b0), .Req1_Byte_in(b1),
    .Req0_Last_in(l0), .Req1_Last_in(l1),
    .Req0_Ready_out(r0), .Req1_Ready_out(r1),
    .Tx_DV_out(dv), .Tx_Byte_out(tx_byte), .Tx_Done_in(done),
    .Grant_out(grant), .Busy_out(busy), .Timeout_out(tmo)
  );

  always #5 clk = ~clk;
  always @(posedge dv) dv_cnt++;

  task cyc;
    @(negedge clk);
    #1;
  endtask

  task do_reset;
    rst = 1; v0 = 0; v1 = 0; done = 0;
    cyc; cyc;
    rst = 0;
    #1;
  endtask

  // entered at a negedge with the DUT in SEND; leaves at the first negedge back in IDLE/HOLD
  task serve_done;
    cyc;
    done = 1;
    cyc;
    done = 0;
    cyc; cyc;
  endtask

  task test_reset;
    rst = 1; v0 = 1; v1 = 1; done = 1;
    cyc; cyc;
    tests++; if (r0 !== 0 || r1 !== 0) begin fails++; $display("FAIL reset_ready: got %b%b expected 00", r1, r0); end
    tests++; if (dv !== 0 || tmo !== 0 || busy !== 0) begin fails++; $display("FAIL reset_flags: dv=%b tmo=%b busy=%b expected 0", dv, tmo, busy); end
    tests++; if (tx_byte !== 8'h00 || grant !== 2'b00) begin fails++; $display("FAIL reset_regs: byte=%h grant=%b expected 00/00", tx_byte, grant); end
    rst = 0; v0 = 0; v1 = 0; done = 0;
    #1;
  endtask

  task test_single;
    do_reset;
    v0 = 1; b0 = 8'h41; l0 = 1;
    #1;
    tests++; if (r0 !== 1 || r1 !== 0) begin fails++; $display("FAIL single_ready: got %b%b expected 01", r1, r0); end
    cyc;
    v0 = 0;
    tests++; if (dv !== 1 || tx_byte !== 8'h41) begin fails++; $display("FAIL single_send: dv=%b byte=%h expected 1/41", dv, tx_byte); end
    tests++; if (grant !== 2'b01 || busy !== 1) begin fails++; $display("FAIL single_grant: grant=%b busy=%b expected 01/1", grant, busy); end
    cyc;
    tests++; if (dv !== 0 || tx_byte !== 8'h41) begin fails++; $display("FAIL single_wait: dv=%b byte=%h expected 0/41", dv, tx_byte); end
    done = 1;
    cyc;
    done = 0;
    tests++; if (grant !== 2'b00 || busy !== 1 || tx_byte !== 8'h41) begin fails++; $display("FAIL single_gap1: grant=%b busy=%b byte=%h expected 00/1/41", grant, busy, tx_byte); end
    v0 = 1; v1 = 1; b1 = 8'h55; l1 = 1;
    #1;
    tests++; if (r0 !== 0 || r1 !== 0) begin fails++; $display("FAIL single_gap1_ready: got %b%b expected 00", r1, r0); end
    cyc;
    tests++; if (r0 !== 0 || r1 !== 0 || busy !== 1) begin fails++; $display("FAIL single_gap2: ready=%b%b busy=%b expected 00/1", r1, r0, busy); end
    cyc;
    tests++; if (busy !== 0 || r1 !== 1 || r0 !== 0) begin fails++; $display("FAIL single_ptr: busy=%b ready=%b%b expected 0/10", busy, r1, r0); end
    cyc;
    v0 = 0; v1 = 0;
    tests++; if (dv !== 1 || tx_byte !== 8'h55 || grant !== 2'b10) begin fails++; $display("FAIL single_req1: dv=%b byte=%h grant=%b expected 1/55/10", dv, tx_byte, grant); end
    serve_done;
  endtask

  task test_contention;
    do_reset;
    v0 = 1; v1 = 1; b0 = 8'hA0; b1 = 8'hA1; l0 = 1; l1 = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (r0 !== ((k % 2) == 0) || r1 !== ((k % 2) == 1)) begin fails++; $display("FAIL contend_ready%0d: got %b%b expected %b%b", k, r1, r0, (k % 2) == 1, (k % 2) == 0); end
      cyc;
      tests++; if (dv !== 1 || tx_byte !== ((k % 2) ? 8'hA1 : 8'hA0)) begin fails++; $display("FAIL contend_send%0d: dv=%b byte=%h expected 1/%h", k, dv, tx_byte, (k % 2) ? 8'hA1 : 8'hA0); end
      tests++; if (grant !== ((k % 2) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL contend_grant%0d: got %b expected %b", k, grant, (k % 2) ? 2'b10 : 2'b01); end
      serve_done;
    end
    v0 = 0; v1 = 0;
  endtask

  task test_lock;
    do_reset;
    snap = dv_cnt;
    v1 = 1; b1 = 8'h10; l1 = 0;
    #1;
    tests++; if (r1 !== 1 || r0 !== 0) begin fails++; $display("FAIL lock_first: got %b%b expected 10", r1, r0); end
    cyc;
    v0 = 1; b0 = 8'h20; l0 = 1; b1 = 8'h11; l1 = 0;
    serve_done;
    tests++; if (r1 !== 1 || r0 !== 0 || grant !== 2'b10) begin fails++; $display("FAIL lock_hold1: ready=%b%b grant=%b expected 10/10", r1, r0, grant); end
    cyc;
    tests++; if (dv !== 1 || tx_byte !== 8'h11) begin fails++; $display("FAIL lock_byte11: dv=%b byte=%h expected 1/11", dv, tx_byte); end
    b1 = 8'h12; l1 = 1;
    serve_done;
    tests++; if (r1 !== 1 || r0 !== 0) begin fails++; $display("FAIL lock_hold2: got %b%b expected 10", r1, r0); end
    cyc;
    v1 = 0;
    tests++; if (dv !== 1 || tx_byte !== 8'h12 || grant !== 2'b10) begin fails++; $display("FAIL lock_byte12: dv=%b byte=%h grant=%b expected 1/12/10", dv, tx_byte, grant); end
    serve_done;
    tests++; if (r0 !== 1 || busy !== 0) begin fails++; $display("FAIL lock_release: r0=%b busy=%b expected 1/0", r0, busy); end
    cyc;
    v0 = 0;
    tests++; if (tx_byte !== 8'h20 || grant !== 2'b01 || dv_cnt - snap !== 4) begin fails++; $display("FAIL lock_req0: byte=%h grant=%b dvs=%0d expected 20/01/4", tx_byte, grant, dv_cnt - snap); end
    serve_done;
  endtask

  task test_timeout;
    do_reset;
    v0 = 1; b0 = 8'h30; l0 = 0;
    cyc;
    v0 = 0;
    serve_done;
    v1 = 1; b1 = 8'h40; l1 = 1;
    #1;
    tests++; if (r0 !== 1 || r1 !== 0 || grant !== 2'b01 || busy !== 1) begin fails++; $display("FAIL tmo_hold: ready=%b%b grant=%b busy=%b expected 01/01/1", r1, r0, grant, busy); end
    for (int i = 0; i < 7; i++) begin
      cyc;
      tests++; if (tmo !== 0 || busy !== 1) begin fails++; $display("FAIL tmo_early%0d: tmo=%b busy=%b expected 0/1", i, tmo, busy); end
    end
    cyc;
    tests++; if (tmo !== 1 || grant !== 2'b00 || busy !== 0 || r1 !== 1) begin fails++; $display("FAIL tmo_fire: tmo=%b grant=%b busy=%b r1=%b expected 1/00/0/1", tmo, grant, busy, r1); end
    cyc;
    v1 = 0;
    tests++; if (tmo !== 0 || dv !== 1 || tx_byte !== 8'h40 || grant !== 2'b10) begin fails++; $display("FAIL tmo_next: tmo=%b dv=%b byte=%h grant=%b expected 0/1/40/10", tmo, dv, tx_byte, grant); end
    serve_done;
  endtask

  task test_accept_at_timeout;
    do_reset;
    v0 = 1; b0 = 8'h30; l0 = 0;
    cyc;
    v0 = 0;
    serve_done;
    for (int i = 0; i < 7; i++) cyc;
    v0 = 1; b0 = 8'h31; l0 = 1;
    cyc;
    v0 = 0;
    tests++; if (tmo !== 0 || dv !== 1 || tx_byte !== 8'h31 || grant !== 2'b01) begin fails++; $display("FAIL edge_accept: tmo=%b dv=%b byte=%h grant=%b expected 0/1/31/01", tmo, dv, tx_byte, grant); end
    cyc;
    tests++; if (tmo !== 0) begin fails++; $display("FAIL edge_no_tmo: got %b expected 0", tmo); end
    serve_done;
  endtask

  task test_reset_wait;
    do_reset;
    v0 = 1; b0 = 8'h50; l0 = 1;
    cyc;
    v0 = 0;
    cyc;
    snap = dv_cnt;
    rst = 1;
    cyc;
    rst = 0;
    tests++; if (busy !== 0 || grant !== 2'b00 || tx_byte !== 8'h00 || dv !== 0) begin fails++; $display("FAIL rstwait_regs: busy=%b grant=%b byte=%h dv=%b expected 0/00/00/0", busy, grant, tx_byte, dv); end
    done = 1;
    cyc;
    done = 0;
    cyc; cyc;
    tests++; if (busy !== 0 || dv_cnt !== snap || grant !== 2'b00) begin fails++; $display("FAIL rstwait_done: busy=%b dvs=%0d grant=%b expected 0/%0d/00", busy, dv_cnt, grant, snap); end
    v0 = 1; v1 = 1; l0 = 1; l1 = 1;
    #1;
    tests++; if (r0 !== 1 || r1 !== 0) begin fails++; $display("FAIL rstwait_ptr: got %b%b expected 01", r1, r0); end
    v0 = 0; v1 = 0;
    #1;
  endtask

  task test_spurious;
    do_reset;
    snap = dv_cnt;
    done = 1;
    cyc;
    done = 0;
    tests++; if (busy !== 0 || dv !== 0) begin fails++; $display("FAIL spur_idle: busy=%b dv=%b expected 0/0", busy, dv); end
    v0 = 1; b0 = 8'h60; l0 = 0;
    cyc;
    v0 = 0;
    cyc;
    done = 1;
    cyc;
    cyc;
    tests++; if (busy !== 1 || grant !== 2'b01 || dv !== 0) begin fails++; $display("FAIL spur_gap: busy=%b grant=%b dv=%b expected 1/01/0", busy, grant, dv); end
    cyc;
    tests++; if (busy !== 1 || r0 !== 1 || dv !== 0) begin fails++; $display("FAIL spur_hold1: busy=%b r0=%b dv=%b expected 1/1/0", busy, r0, dv); end
    cyc;
    done = 0;
    tests++; if (busy !== 1 || r0 !== 1 || dv !== 0 || grant !== 2'b01 || dv_cnt - snap !== 1) begin fails++; $display("FAIL spur_hold2: busy=%b r0=%b dv=%b grant=%b dvs=%0d expected 1/1/0/01/1", busy, r0, dv, grant, dv_cnt - snap); end
    v0 = 1; b0 = 8'h61; l0 = 1;
    cyc;
    v0 = 0;
    tests++; if (dv !== 1 || tx_byte !== 8'h61) begin fails++; $display("FAIL spur_resume: dv=%b byte=%h expected 1/61", dv, tx_byte); end
    serve_done;
  endtask

  initial begin
    cyc;
    test_reset;
    test_single;
    test_contention;
    test_lock;
    test_timeout;
    test_accept_at_timeout;
    test_reset_wait;
    test_spurious;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
